// File: rtl/param_readback_tx.sv
// param_readback_tx: UART 8N1 transmitter that returns the active pulse-sequence
// parameters to the host as one frame: HEADER, 20 payload bytes, optional CHK.
// Build option: define PARAM_TX_CHKSUM_EN to append an XOR checksum byte.
module param_readback_tx #(
    parameter int unsigned BAUD_DIV = 104,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        send,
    input  logic [7:0]  per,
    input  logic [15:0] p1wid,
    input  logic [15:0] del,
    input  logic [15:0] p2wid,
    input  logic [31:0] nut_d,
    input  logic [31:0] nut_w,
    input  logic [7:0]  cp,
    input  logic [7:0]  p_bl,
    input  logic [15:0] p_bl_off,
    input  logic [2:0]  flags,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned      CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
`ifdef PARAM_TX_CHKSUM_EN
    localparam logic [4:0]       LAST_BYTE = 5'd21;
`else
    localparam logic [4:0]       LAST_BYTE = 5'd20;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [4:0]         byte_idx_q, byte_idx_d;
    logic [159:0]       snap_q, snap_d;
    logic [159:0]       snap_in;
    logic               accept;
    logic               bit_end;
    logic [4:0]         payload_sel;
    logic [7:0]         cur_byte;

    // Payload in transmit order, MSB byte of each field first
    assign snap_in = {per, p1wid, del, p2wid, nut_d, nut_w, cp, p_bl, p_bl_off, 5'b0, flags};
    assign accept  = (state_q == IDLE) && send;

`ifdef PARAM_TX_CHKSUM_EN
    logic [7:0] chk_q, chk_d;

    // Checksum of the payload, captured on the same edge as the snapshot
    always_comb begin
        chk_d = chk_q;
        if (accept) begin
            chk_d = '0;
            for (int unsigned i = 0; i < 20; i++) begin
                chk_d = chk_d ^ snap_in[8*i +: 8];
            end
        end
    end

    // Checksum register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    // Select the byte currently on the line from header, snapshot or checksum
    always_comb begin
        payload_sel = 5'd20 - byte_idx_q;
        cur_byte    = snap_q[{payload_sel, 3'b000} +: 8];
        if (byte_idx_q == 5'd0) begin
            cur_byte = HEADER;
        end
`ifdef PARAM_TX_CHKSUM_EN
        else if (byte_idx_q == 5'd21) begin
            cur_byte = chk_q;
        end
`endif
    end

    // State, counters and snapshot registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            snap_q     <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            snap_q     <= snap_d;
        end
    end

    // Next-state: bit timing, bit/byte sequencing and request acceptance
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        snap_d     = snap_q;
        bit_end    = (baud_cnt_q == BAUD_LAST);

        if (state_q == START || state_q == DATA || state_q == STOP) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    snap_d     = snap_in;
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = FINISH;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = START;
                    end
                end
            end
            FINISH: begin
                state_d    = IDLE;
                byte_idx_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state; tx idles high
    always_comb begin
        tx   = 1'b1;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            START: begin
                tx   = 1'b0;
                busy = 1'b1;
            end
            DATA: begin
                tx   = cur_byte[bit_idx_q];
                busy = 1'b1;
            end
            STOP: begin
                busy = 1'b1;
            end
            FINISH: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_param_readback_tx.sv
// tb_param_readback_tx: directed sequence with randomized parameter sets for
// param_readback_tx; a UART line decoder rebuilds the bytes and a frame model
// built from the field layout supplies the expected contents.
module tb_param_readback_tx;

    localparam int unsigned BAUD     = 104;
    localparam int unsigned BYTE_CYC = 10 * BAUD;
`ifdef PARAM_TX_CHKSUM_EN
    localparam int unsigned NBYTES   = 22;
`else
    localparam int unsigned NBYTES   = 21;
`endif
    localparam int unsigned FRAME_CYC = NBYTES * BYTE_CYC;

    typedef struct {
        logic [7:0]  per;
        logic [15:0] p1wid;
        logic [15:0] del;
        logic [15:0] p2wid;
        logic [31:0] nut_d;
        logic [31:0] nut_w;
        logic [7:0]  cp;
        logic [7:0]  p_bl;
        logic [15:0] p_bl_off;
        logic [2:0]  flags;
    } params_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        send = 1'b0;
    logic [7:0]  per = '0;
    logic [15:0] p1wid = '0;
    logic [15:0] del = '0;
    logic [15:0] p2wid = '0;
    logic [31:0] nut_d = '0;
    logic [31:0] nut_w = '0;
    logic [7:0]  cp = '0;
    logic [7:0]  p_bl = '0;
    logic [15:0] p_bl_off = '0;
    logic [2:0]  flags = '0;
    logic        tx;
    logic        busy;
    logic        done;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];

    param_readback_tx #(
        .BAUD_DIV (BAUD),
        .HEADER   (8'hA5)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .send     (send),
        .per      (per),
        .p1wid    (p1wid),
        .del      (del),
        .p2wid    (p2wid),
        .nut_d    (nut_d),
        .nut_w    (nut_w),
        .cp       (cp),
        .p_bl     (p_bl),
        .p_bl_off (p_bl_off),
        .flags    (flags),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: rebuilds bytes from tx and tracks bit-grid / gap errors
    int unsigned timing_errs = 0;
    int unsigned gap_errs = 0;
    int unsigned framing_errs = 0;
    logic        mon_frame = 1'b0;
    logic        mon_in_byte = 1'b0;
    logic        prev_tx = 1'b1;
    int unsigned origin = 0;
    int unsigned byte_start = 0;
    logic [9:0]  shreg = '0;

    always @(negedge clk) begin
        int unsigned off;
        int unsigned k;
        if (!resetn) begin
            mon_frame   = 1'b0;
            mon_in_byte = 1'b0;
            prev_tx     = 1'b1;
        end else begin
            if (mon_frame && (tx !== prev_tx) && (((cyc - origin) % BAUD) != 0))
                timing_errs++;
            if (!mon_in_byte) begin
                if (tx === 1'b0) begin
                    if (!mon_frame) begin
                        mon_frame = 1'b1;
                        origin    = cyc;
                        rx_q.delete();
                    end else if ((cyc - origin) != rx_q.size() * BYTE_CYC) begin
                        gap_errs++;
                    end
                    mon_in_byte = 1'b1;
                    byte_start  = cyc;
                end
            end else begin
                off = cyc - byte_start;
                if ((off % BAUD) == BAUD / 2) begin
                    k = off / BAUD;
                    shreg[k] = tx;
                    if (k == 9) begin
                        if (shreg[0] !== 1'b0 || shreg[9] !== 1'b1) framing_errs++;
                        rx_q.push_back(shreg[8:1]);
                        mon_in_byte = 1'b0;
                    end
                end
            end
            if (done === 1'b1) mon_frame = 1'b0;
            prev_tx = tx;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic params_t rand_params();
        params_t p;
        p.per      = 8'($urandom);
        p.p1wid    = 16'($urandom);
        p.del      = 16'($urandom);
        p.p2wid    = 16'($urandom);
        p.nut_d    = $urandom;
        p.nut_w    = $urandom;
        p.cp       = 8'($urandom);
        p.p_bl     = 8'($urandom);
        p.p_bl_off = 16'($urandom);
        p.flags    = 3'($urandom);
        return p;
    endfunction

    task automatic apply(input params_t p);
        per = p.per; p1wid = p.p1wid; del = p.del; p2wid = p.p2wid;
        nut_d = p.nut_d; nut_w = p.nut_w; cp = p.cp; p_bl = p.p_bl;
        p_bl_off = p.p_bl_off; flags = p.flags;
    endtask

    // Expected frame: header, fields MSB byte first, optional XOR of payload
    task automatic build_expected(input params_t p);
        logic [7:0] c;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(p.per);
        for (int i = 1; i >= 0; i--) exp_q.push_back(p.p1wid[8*i +: 8]);
        for (int i = 1; i >= 0; i--) exp_q.push_back(p.del[8*i +: 8]);
        for (int i = 1; i >= 0; i--) exp_q.push_back(p.p2wid[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp_q.push_back(p.nut_d[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp_q.push_back(p.nut_w[8*i +: 8]);
        exp_q.push_back(p.cp);
        exp_q.push_back(p.p_bl);
        for (int i = 1; i >= 0; i--) exp_q.push_back(p.p_bl_off[8*i +: 8]);
        exp_q.push_back({5'b0, p.flags});
        c = '0;
        for (int i = 1; i <= 20; i++) c = c ^ exp_q[i];
`ifdef PARAM_TX_CHKSUM_EN
        exp_q.push_back(c);
`endif
    endtask

    task automatic compare_bytes(input string tag, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            if (i < rx_q.size())
                check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
            else
                check($sformatf("%s_byte%0d_missing", tag, i), 1'b0, 1'b1);
        end
    endtask

    task automatic do_send(output int unsigned acc);
        @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        acc = cyc;
        check("start_bit_latency", tx, 1'b0);
        check("busy_after_accept", busy, 1'b1);
    endtask

    // Wait for done with a cycle budget; optional mid-frame send pulse and p2wid change
    task automatic wait_done(input int unsigned acc, input int unsigned pulse_at,
                             input int unsigned p2_at, input logic [15:0] p2_new,
                             output int unsigned lat, output int unsigned gaps);
        int unsigned n;
        gaps = 0;
        for (int unsigned t = 0; t < FRAME_CYC + 50; t++) begin
            @(negedge clk);
            n = cyc - acc;
            send = (pulse_at != 0 && n == pulse_at);
            if (p2_at != 0 && n == p2_at) p2wid = p2_new;
            if (done === 1'b1) break;
            if (busy !== 1'b1) gaps++;
        end
        send = 1'b0;
        lat = cyc - acc;
    endtask

    initial begin
        params_t     p;
        int unsigned acc;
        int unsigned lat;
        int unsigned gaps;
        logic [15:0] new_p2;

        // Reset state
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_tx", tx, 1'b1);
        check("idle_busy", busy, 1'b0);

        // Directed frame with mid-frame ignored send and late p2wid change
        p = rand_params();
        p.per = 8'h3C; p.p1wid = 16'h0102; p.del = '0; p.p2wid = '0;
        p.nut_d = 32'hDEADBEEF; p.nut_w = '0; p.cp = '0; p.p_bl = '0;
        p.p_bl_off = '0; p.flags = 3'b101;
        apply(p);
        build_expected(p);
        new_p2 = 16'($urandom) | 16'h0001;
        do_send(acc);
        wait_done(acc, 5000, 100, new_p2, lat, gaps);
        check("f1_latency", lat, FRAME_CYC);
        check("f1_busy_hold", gaps, 0);
        check("f1_tx_at_done", tx, 1'b1);
        check("f1_busy_at_done", busy, 1'b0);
        check("f1_len", rx_q.size(), NBYTES);
        compare_bytes("f1", NBYTES);

        // Send during the done cycle is dropped
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check("finish_send_busy", busy, 1'b0);
        check("finish_send_tx", tx, 1'b1);

        // Second frame carries the new p2wid
        p = rand_params();
        p.p2wid = new_p2;
        apply(p);
        build_expected(p);
        do_send(acc);
        wait_done(acc, 0, 0, '0, lat, gaps);
        check("f2_latency", lat, FRAME_CYC);
        check("f2_busy_hold", gaps, 0);
        check("f2_len", rx_q.size(), NBYTES);
        compare_bytes("f2", NBYTES);

        // Third frame aborted by reset inside the nut_w byte
        p = rand_params();
        apply(p);
        build_expected(p);
        do_send(acc);
        for (int unsigned t = 0; t < FRAME_CYC; t++) begin
            @(negedge clk);
            if (cyc - acc >= 13 * BYTE_CYC + 500) break;
        end
        check("abort_point", cyc - acc, 13 * BYTE_CYC + 500);
        check("abort_len", rx_q.size(), 13);
        compare_bytes("f3", 13);
        #2 resetn = 1'b0;
        #1;
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        check("post_abort_tx", tx, 1'b1);
        check("post_abort_busy", busy, 1'b0);
        check("post_abort_done", done, 1'b0);

        // Clean frame after the abort
        p = rand_params();
        apply(p);
        build_expected(p);
        do_send(acc);
        wait_done(acc, 0, 0, '0, lat, gaps);
        check("f4_latency", lat, FRAME_CYC);
        check("f4_busy_hold", gaps, 0);
        check("f4_len", rx_q.size(), NBYTES);
        compare_bytes("f4", NBYTES);

        // Line-level timing over all frames
        check("bit_grid_errors", timing_errs, 0);
        check("byte_gap_errors", gap_errs, 0);
        check("framing_errors", framing_errs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
